// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: halt/run/step/breakpoint sequencer gating the RV32 core's state enable.
// Optional RUN_CTRL_CYCLE_LIMIT_EN adds cycle_limit/limit_hit to bound free-running.
module cpu_run_ctrl #(
  parameter int CNT_W = 32,
  parameter int STEP_W = 8,
  parameter bit RUN_ON_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_count,
  input  logic [31:0]       pc,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  input  logic [CNT_W-1:0]  cycle_limit,
  output logic              limit_hit,
`endif
  output logic              cpu_en,
  output logic              halted,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  retired,
  output logic [1:0]        state
);
  typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10, BRK = 2'b11} state_t;
  state_t st;
  logic [STEP_W-1:0] remain;
  logic [STEP_W-1:0] load;
  logic skip;
  logic bp_match;
  logic lim;
  assign state = st;
  assign halted = st == HALT || st == BRK;
  assign bp_match = bp_en && pc == bp_addr && !skip;
  assign cpu_en = st == RUN ? !halt_req && !bp_match : st == STEP ? !halt_req : 1'b0;
  assign load = step_count == '0 ? STEP_W'(1) : step_count;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  assign lim = cycle_limit != '0 && cpu_en && retired == cycle_limit - CNT_W'(1);
`else
  assign lim = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= RUN_ON_RESET ? RUN : HALT;
      retired <= '0;
      bp_hit <= 1'b0;
      remain <= '0;
      skip <= 1'b0;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
      limit_hit <= 1'b0;
`endif
    end else begin
      retired <= retired + CNT_W'(cpu_en);
      if (cpu_en) skip <= 1'b0;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
      if ((st == HALT || st == BRK) && !halt_req && (run_req || step_req)) limit_hit <= 1'b0;
`endif
      case (st)
        HALT: begin
          if (!halt_req && step_req) begin
            st <= STEP;
            remain <= load;
          end else if (!halt_req && run_req) st <= RUN;
        end
        RUN: begin
          if (halt_req) begin
            st <= HALT;
            skip <= 1'b0;
          end else if (bp_match) begin
            st <= BRK;
            bp_hit <= 1'b1;
          end else if (lim) begin
            st <= HALT;
            skip <= 1'b0;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
            limit_hit <= 1'b1;
`endif
          end
        end
        STEP: begin
          if (halt_req) begin
            st <= HALT;
            remain <= '0;
            skip <= 1'b0;
          end else begin
            remain <= remain - STEP_W'(1);
            if (remain == STEP_W'(1)) begin
              st <= HALT;
              skip <= 1'b0;
            end
          end
        end
        BRK: begin
          if (halt_req) begin
            st <= HALT;
            bp_hit <= 1'b0;
            skip <= 1'b0;
          end else if (step_req) begin
            st <= STEP;
            remain <= load;
            bp_hit <= 1'b0;
          end else if (run_req) begin
            // resume executes the trapped instruction once instead of re-trapping
            st <= RUN;
            skip <= 1'b1;
            bp_hit <= 1'b0;
          end
        end
        default: st <= HALT;
      endcase
    end
  end
endmodule
